// File: rtl/tetris_input.sv
// Button conditioner for the Tetris game: synchronizes and debounces two raw
// buttons, then turns them into single-cycle move/rotate commands with auto-repeat.
module tetris_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CHORD_WINDOW    = 1260000,
  parameter int REPEAT_DELAY    = 6300000,
  parameter int REPEAT_PERIOD   = 2520000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_left,
  input  logic btn_right,
  output logic move_left,
  output logic move_right,
  output logic rotate,
  output logic held_left,
  output logic held_right
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW   = $clog2(CHORD_WINDOW + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_CHORD, HELD, CHORD} state_t;

  // Bit 0 is the left button, bit 1 the right button throughout.
  logic [1:0]    s1, s2, stable;
  logic [DW-1:0] db_cnt [2];

  state_t        state, state_nxt;
  logic          side, side_nxt;
  logic [WW-1:0] win_cnt, win_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt, rep_limit;
  logic          first, first_nxt;
  logic          go_move, rot_nxt;
  logic          side_lvl, other_lvl;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= {btn_right, btn_left};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign held_left  = stable[0];
  assign held_right = stable[1];

  assign side_lvl  = side ? stable[1] : stable[0];
  assign other_lvl = side ? stable[0] : stable[1];
  assign rep_limit = first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      side       <= 1'b0;
      win_cnt    <= '0;
      rep_cnt    <= '0;
      first      <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      rotate     <= 1'b0;
    end else begin
      state      <= state_nxt;
      side       <= side_nxt;
      win_cnt    <= win_nxt;
      rep_cnt    <= rep_nxt;
      first      <= first_nxt;
      move_left  <= go_move & ~side;
      move_right <= go_move & side;
      rotate     <= rot_nxt;
    end
  end

  // A single press waits for its partner; a chord always wins over a move.
  always_comb begin
    state_nxt = state;
    side_nxt  = side;
    win_nxt   = win_cnt;
    rep_nxt   = rep_cnt;
    first_nxt = first;
    go_move   = 1'b0;
    rot_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (stable[0] && stable[1]) begin
          rot_nxt   = 1'b1;
          state_nxt = CHORD;
        end else if (stable[0] || stable[1]) begin
          side_nxt  = stable[1];
          win_nxt   = '0;
          state_nxt = WAIT_CHORD;
        end
      end
      WAIT_CHORD: begin
        if (other_lvl) begin
          rot_nxt   = 1'b1;
          state_nxt = CHORD;
        end else if (!side_lvl) begin
          go_move   = 1'b1;
          state_nxt = IDLE;
        end else if (win_cnt == WW'(CHORD_WINDOW - 1)) begin
          go_move   = 1'b1;
          rep_nxt   = '0;
          first_nxt = 1'b1;
          state_nxt = HELD;
        end else begin
          win_nxt = win_cnt + 1'b1;
        end
      end
      HELD: begin
        if (other_lvl) begin
          rot_nxt   = 1'b1;
          state_nxt = CHORD;
        end else if (!side_lvl) begin
          state_nxt = IDLE;
        end else if (rep_cnt == rep_limit) begin
          go_move   = 1'b1;
          rep_nxt   = '0;
          first_nxt = 1'b0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
      end
      CHORD: begin
        if (!stable[0] && !stable[1]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tetris_input.sv
// Bench for tetris_input: directed scenarios plus random button activity, all
// checked cycle by cycle against an event-time reference model.
module tb_tetris_input;

  localparam int DB = 4;
  localparam int CW = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  localparam int FREE      = 0;
  localparam int PENDING   = 1;
  localparam int REPEATING = 2;
  localparam int CHORDED   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic move_left, move_right, rotate, held_left, held_right;

  tetris_input #(
    .DEBOUNCE_CYCLES(DB),
    .CHORD_WINDOW(CW),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .move_left(move_left),
    .move_right(move_right),
    .rotate(rotate),
    .held_left(held_left),
    .held_right(held_right)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int edge_no = 0;
  int q_ml[$], q_mr[$], q_rot[$], q_rise_l[$], q_fall_l[$], q_rise_r[$];
  logic prev_hl = 1'b0;
  logic prev_hr = 1'b0;

  bit m_p1 [2];
  bit m_p2 [2];
  bit m_lvl [2];
  int m_run [2];
  int m_mode;
  bit m_side;
  int m_t0, m_next;
  bit exp_ml, exp_mr, exp_rot;

  // Model: raw seen two edges late, a level flips after DB+1 consecutive
  // disagreeing samples, and commands are scheduled by absolute edge numbers.
  task automatic model_step(input bit rst_n, input bit raw_l, input bit raw_r);
    bit L, R, mine, other;
    exp_ml = 1'b0;
    exp_mr = 1'b0;
    exp_rot = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_lvl[i] = 1'b0; m_run[i] = 0;
      end
      m_mode = FREE;
      return;
    end
    L = m_lvl[0];
    R = m_lvl[1];
    mine  = m_side ? R : L;
    other = m_side ? L : R;
    case (m_mode)
      FREE: begin
        if (L && R) begin
          exp_rot = 1'b1; m_mode = CHORDED;
        end else if (L || R) begin
          m_side = R; m_t0 = edge_no; m_mode = PENDING;
        end
      end
      PENDING: begin
        if (other) begin
          exp_rot = 1'b1; m_mode = CHORDED;
        end else if (!mine) begin
          if (m_side) exp_mr = 1'b1; else exp_ml = 1'b1;
          m_mode = FREE;
        end else if (edge_no == m_t0 + CW) begin
          if (m_side) exp_mr = 1'b1; else exp_ml = 1'b1;
          m_mode = REPEATING;
          m_next = edge_no + RD;
        end
      end
      REPEATING: begin
        if (other) begin
          exp_rot = 1'b1; m_mode = CHORDED;
        end else if (!mine) begin
          m_mode = FREE;
        end else if (edge_no == m_next) begin
          if (m_side) exp_mr = 1'b1; else exp_ml = 1'b1;
          m_next = edge_no + RP;
        end
      end
      default: begin
        if (!L && !R) m_mode = FREE;
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      if (m_p2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB + 1) begin
          m_lvl[i] = m_p2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_p2 = m_p1;
    m_p1[0] = raw_l;
    m_p1[1] = raw_r;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, edge_no);
    end
  endtask

  task automatic checkOutput();
    check_val("move_left", 32'(move_left), 32'(exp_ml));
    check_val("move_right", 32'(move_right), 32'(exp_mr));
    check_val("rotate", 32'(rotate), 32'(exp_rot));
    check_val("held_left", 32'(held_left), 32'(m_lvl[0]));
    check_val("held_right", 32'(held_right), 32'(m_lvl[1]));
    if (move_left === 1'b1) q_ml.push_back(edge_no);
    if (move_right === 1'b1) q_mr.push_back(edge_no);
    if (rotate === 1'b1) q_rot.push_back(edge_no);
    if (held_left === 1'b1 && prev_hl !== 1'b1) q_rise_l.push_back(edge_no);
    if (held_left === 1'b0 && prev_hl === 1'b1) q_fall_l.push_back(edge_no);
    if (held_right === 1'b1 && prev_hr !== 1'b1) q_rise_r.push_back(edge_no);
    prev_hl = held_left;
    prev_hr = held_right;
  endtask

  task automatic applyStimulus(input bit rst_n, input bit l, input bit r, input int n);
    reset_n = rst_n;
    btn_left = l;
    btn_right = r;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      edge_no++;
      model_step(rst_n, l, r);
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic clear_logs();
    q_ml.delete(); q_mr.delete(); q_rot.delete();
    q_rise_l.delete(); q_fall_l.delete(); q_rise_r.delete();
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  initial begin
    int k;
    int h;
    int s3_exp [8];
    bit rl, rr;
    int n;
    s3_exp = '{9, 29, 34, 39, 44, 49, 54, 59};
    m_mode = FREE;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 3);
    applyStimulus(1, 0, 0, 5);

    $display("[TB] bounce on left then steady press");
    clear_logs();
    for (int i = 0; i < 14; i++) applyStimulus(1, (i % 2) == 0, 0, 2);
    check_val("bounce_moves", q_ml.size() + q_mr.size(), 0);
    check_val("bounce_rotate", q_rot.size(), 0);
    check_val("bounce_held", q_rise_l.size(), 0);
    k = edge_no + 1;
    applyStimulus(1, 1, 0, 22);
    check_val("bounce_rise_count", q_rise_l.size(), 1);
    check_val("bounce_rise_time", q_at(q_rise_l, 0) - k, 6);
    applyStimulus(1, 0, 0, 20);

    $display("[TB] left tap");
    clear_logs();
    applyStimulus(1, 1, 0, 5);
    applyStimulus(1, 0, 0, 20);
    check_val("tap_count", q_ml.size(), 1);
    check_val("tap_time", q_at(q_ml, 0) - q_at(q_fall_l, 0), 1);
    check_val("tap_rotate", q_rot.size() + q_mr.size(), 0);

    $display("[TB] right held with auto-repeat");
    clear_logs();
    applyStimulus(1, 0, 1, 60);
    applyStimulus(1, 0, 0, 30);
    h = q_at(q_rise_r, 0);
    check_val("repeat_count", q_mr.size(), 8);
    for (int i = 0; i < 8; i++) check_val("repeat_time", q_at(q_mr, i) - h, s3_exp[i]);
    check_val("repeat_others", q_ml.size() + q_rot.size(), 0);

    $display("[TB] staggered chord and re-press");
    clear_logs();
    applyStimulus(1, 1, 0, 3);
    applyStimulus(1, 1, 1, 20);
    applyStimulus(1, 0, 1, 20);
    applyStimulus(1, 1, 1, 20);
    applyStimulus(1, 0, 0, 20);
    check_val("chord_rotate", q_rot.size(), 1);
    check_val("chord_moves", q_ml.size() + q_mr.size(), 0);
    clear_logs();
    applyStimulus(1, 0, 1, 5);
    applyStimulus(1, 0, 0, 20);
    check_val("post_chord_tap", q_mr.size(), 1);
    check_val("post_chord_other", q_ml.size() + q_rot.size(), 0);

    $display("[TB] simultaneous press, then chord during repeat");
    clear_logs();
    k = edge_no + 1;
    applyStimulus(1, 1, 1, 20);
    applyStimulus(1, 0, 0, 20);
    check_val("simul_rotate_count", q_rot.size(), 1);
    check_val("simul_rotate_time", q_at(q_rot, 0) - k, 7);
    check_val("simul_moves", q_ml.size() + q_mr.size(), 0);
    clear_logs();
    k = edge_no + 1;
    applyStimulus(1, 1, 0, 40);
    applyStimulus(1, 1, 1, 30);
    applyStimulus(1, 0, 0, 20);
    check_val("held_chord_rotate", q_at(q_rot, 0) - k, 47);
    check_val("held_chord_moves", q_ml.size(), 4);
    check_val("held_chord_last_move", q_at(q_ml, 3) - k, 45);

    $display("[TB] reset during repeat");
    applyStimulus(1, 1, 0, 40);
    clear_logs();
    applyStimulus(0, 1, 0, 3);
    applyStimulus(1, 1, 0, 30);
    check_val("reset_rise_count", q_rise_l.size(), 1);
    check_val("reset_first_move", q_at(q_ml, 0) - q_at(q_rise_l, 0), CW + 1);
    applyStimulus(1, 0, 0, 20);

    $display("[TB] random activity");
    for (int s = 0; s < 200; s++) begin
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 45));
      if ($urandom_range(0, 19) == 0) applyStimulus(0, rl, rr, int'($urandom_range(1, 3)));
      applyStimulus(1, rl, rr, n);
    end
    applyStimulus(1, 0, 0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
